// File: rtl/note_event_scheduler_pkg.sv
// Shared types and helpers for note_event_scheduler (see SCHED_BARLINE_EN in the top).
package note_event_scheduler_pkg;

   typedef enum logic [1:0] {DurEighth, DurQuarter, DurHalf, DurWhole} dur_e;

   typedef struct packed {
      logic       rest;
      dur_e       dur;
      logic [5:0] tone;
   } event_t;

   typedef struct packed {
      logic       bar;
      logic       tie;
      logic       rest;
      dur_e       dur;
      logic [5:0] tone;
   } score_rec_t;

   typedef enum logic [2:0] {StIdle, StLoad, StEmit, StBar, StHalt} state_e;

   // Largest power of two that fits both the remaining note and the rest of the measure.
   function automatic logic [3:0] frag_len(input logic [3:0] left, input logic [3:0] pos,
                                           input logic [3:0] meas);
      logic [3:0] room;
      logic [3:0] lim;
      room = meas - pos;
      lim  = (left < room) ? left : room;
      if (lim[3])      return 4'd8;
      else if (lim[2]) return 4'd4;
      else if (lim[1]) return 4'd2;
      else             return 4'd1;
   endfunction

   function automatic score_rec_t make_rec(input event_t ev, input logic [3:0] left,
                                           input logic [3:0] pos, input logic [3:0] meas);
      score_rec_t r;
      logic [3:0] frag;
      frag   = frag_len(left, pos, meas);
      r.bar  = 1'b0;
      r.rest = ev.rest;
      r.tie  = !ev.rest && (left != frag);
      r.dur  = frag[3] ? DurWhole : frag[2] ? DurHalf : frag[1] ? DurQuarter : DurEighth;
      r.tone = ev.rest ? 6'd0 : ev.tone;
      return r;
   endfunction

endpackage

// File: rtl/note_event_scheduler_fifo.sv
// event_fifo: power-of-two depth event queue with full/empty flags; push+pop when full is legal.
module event_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/note_event_scheduler.sv
// Splits note events into measure-aligned score records; define SCHED_BARLINE_EN to also
// write a barline record at every measure boundary.
module note_event_scheduler
   import note_event_scheduler_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH      = 8,
   parameter int unsigned MEASURE_EIGHTHS = 8,
   parameter int unsigned ADDR_W          = 9
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              note_valid_in,
   input  logic [5:0]        note_tone_in,
   input  logic [1:0]        note_dur_in,
   input  logic              note_rest_in,
   output logic              wr_valid_out,
   input  logic              wr_ready_in,
   output logic [ADDR_W-1:0] wr_addr_out,
   output logic [10:0]       wr_data_out,
   output logic [7:0]        measure_out,
   output logic              overflow_out,
   output logic              score_full_out,
   output logic              busy_out
);
`ifdef SCHED_BARLINE_EN
   localparam bit BarlineEn = 1'b1;
`else
   localparam bit BarlineEn = 1'b0;
`endif
   localparam logic [3:0]        Meas    = 4'(MEASURE_EIGHTHS);
   localparam logic [ADDR_W-1:0] AddrMax = '1;
   localparam logic [10:0]       BarRec  = 11'h400;

   state_e     state;
   event_t     cur;
   event_t     fifo_dout;
   event_t     fifo_din;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_pop;
   logic [3:0] pos;
   logic [3:0] left;
   logic [3:0] frag;
   logic [3:0] pos_sum;
   logic [3:0] left_rem;
   logic [3:0] load_left;
   logic       wrap;
   logic       at_end;

   assign fifo_din  = '{rest: note_rest_in, dur: dur_e'(note_dur_in), tone: note_tone_in};
   assign fifo_pop  = (state == StLoad);
   assign frag      = frag_len(left, pos, Meas);
   assign pos_sum   = pos + frag;
   assign left_rem  = left - frag;
   assign wrap      = (pos_sum == Meas);
   assign at_end    = (wr_addr_out == AddrMax);
   assign load_left = 4'd1 << fifo_dout.dur;
   assign busy_out  = (state != StIdle) || !fifo_empty;

   event_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH($bits(event_t))
   ) u_fifo (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .push    (note_valid_in),
      .din     (fifo_din),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= StIdle;
         cur            <= '0;
         pos            <= '0;
         left           <= '0;
         wr_addr_out    <= '0;
         wr_valid_out   <= 1'b0;
         wr_data_out    <= '0;
         measure_out    <= '0;
         overflow_out   <= 1'b0;
         score_full_out <= 1'b0;
      end else begin
         if (note_valid_in && fifo_full && !fifo_pop) overflow_out <= 1'b1;
         unique case (state)
            StIdle: if (!fifo_empty) state <= StLoad;
            StLoad: begin
               cur          <= fifo_dout;
               left         <= load_left;
               wr_data_out  <= make_rec(fifo_dout, load_left, pos, Meas);
               wr_valid_out <= 1'b1;
               state        <= StEmit;
            end
            StEmit: if (wr_ready_in) begin
               left <= left_rem;
               pos  <= wrap ? 4'd0 : pos_sum;
               if (wrap && measure_out != 8'hFF) measure_out <= measure_out + 8'd1;
               if (at_end) begin
                  wr_valid_out   <= 1'b0;
                  wr_data_out    <= '0;
                  score_full_out <= 1'b1;
                  state          <= StHalt;
               end else begin
                  wr_addr_out <= wr_addr_out + ADDR_W'(1);
                  if (wrap && BarlineEn) begin
                     wr_data_out <= BarRec;
                     state       <= StBar;
                  end else if (left_rem != 4'd0) begin
                     wr_data_out <= make_rec(cur, left_rem, wrap ? 4'd0 : pos_sum, Meas);
                  end else begin
                     wr_valid_out <= 1'b0;
                     wr_data_out  <= '0;
                     state        <= fifo_empty ? StIdle : StLoad;
                  end
               end
            end
            StBar: if (wr_ready_in) begin
               if (at_end) begin
                  wr_valid_out   <= 1'b0;
                  wr_data_out    <= '0;
                  score_full_out <= 1'b1;
                  state          <= StHalt;
               end else begin
                  wr_addr_out <= wr_addr_out + ADDR_W'(1);
                  if (left != 4'd0) begin
                     wr_data_out <= make_rec(cur, left, pos, Meas);
                     state       <= StEmit;
                  end else begin
                     wr_valid_out <= 1'b0;
                     wr_data_out  <= '0;
                     state        <= fifo_empty ? StIdle : StLoad;
                  end
               end
            end
            StHalt: ;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_note_event_scheduler.sv
// Bench for note_event_scheduler: record-level model plus directed scenarios; honours
// SCHED_BARLINE_EN the same way as the design.
module tb_note_event_scheduler;
`ifdef SCHED_BARLINE_EN
   localparam int B = 1;
`else
   localparam int B = 0;
`endif
   localparam int M = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       note_valid = 1'b0;
   logic       note_rest = 1'b0;
   logic       wr_ready = 1'b0;
   logic [5:0] note_tone = '0;
   logic [1:0] note_dur = '0;

   logic        wr_valid, overflow, score_full, busy;
   logic [8:0]  wr_addr;
   logic [10:0] wr_data;
   logic [7:0]  measure;
   logic        s_valid, s_overflow, s_full, s_busy;
   logic [2:0]  s_addr;
   logic [10:0] s_data;
   logic [7:0]  s_measure;

   logic [10:0] exp_q[$];
   logic [10:0] got[$];
   int          m_pos, m_measure, exp_addr, s_writes;
   int          n_checks = 0;
   int          n_pass = 0;
   logic        exp_ovf;
   logic        stalled = 1'b0;
   logic        s_watch = 1'b0;
   logic [8:0]  held_addr;
   logic [10:0] held_data;

   always #5 clk = ~clk;

   note_event_scheduler dut (
      .clk_in(clk), .rst_n_in(rst_n), .note_valid_in(note_valid), .note_tone_in(note_tone),
      .note_dur_in(note_dur), .note_rest_in(note_rest), .wr_valid_out(wr_valid),
      .wr_ready_in(wr_ready), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
      .measure_out(measure), .overflow_out(overflow), .score_full_out(score_full),
      .busy_out(busy)
   );

   note_event_scheduler #(.ADDR_W(3)) dut_small (
      .clk_in(clk), .rst_n_in(rst_n), .note_valid_in(note_valid), .note_tone_in(note_tone),
      .note_dur_in(note_dur), .note_rest_in(note_rest), .wr_valid_out(s_valid),
      .wr_ready_in(wr_ready), .wr_addr_out(s_addr), .wr_data_out(s_data),
      .measure_out(s_measure), .overflow_out(s_overflow), .score_full_out(s_full),
      .busy_out(s_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
   endtask

   // Score the event as notation: split at measure lines into power-of-two pieces.
   task automatic model_add(input logic rest, input logic [1:0] dur, input logic [5:0] tone);
      int left, lim, frag, code;
      logic tie;
      left = 1 << dur;
      while (left > 0) begin
         lim  = (left < M - m_pos) ? left : M - m_pos;
         frag = 1;
         code = 0;
         while (frag * 2 <= lim) begin
            frag = frag * 2;
            code++;
         end
         tie = !rest && (left != frag);
         exp_q.push_back({1'b0, tie, rest, code[1:0], rest ? 6'd0 : tone});
         m_pos += frag;
         left  -= frag;
         if (m_pos == M) begin
            m_pos = 0;
            if (m_measure < 255) m_measure++;
`ifdef SCHED_BARLINE_EN
            exp_q.push_back(11'h400);
`endif
         end
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      got.delete();
      m_pos = 0;
      m_measure = 0;
      exp_addr = 0;
      exp_ovf = 1'b0;
      s_writes = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic rest, input logic [1:0] dur, input logic [5:0] tone,
                       input bit accepted);
      note_valid = 1'b1;
      note_rest  = rest;
      note_dur   = dur;
      note_tone  = tone;
      if (accepted) model_add(rest, dur, tone);
      idle(1);
      note_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      note_valid = 1'b0;
      idle(2);
      model_clear();
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic drain_and_check(input string tag);
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0 && !busy) break;
         idle(1);
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_measure"}, measure, m_measure);
      check({tag, "_overflow"}, overflow, exp_ovf);
   endtask

   // Every completed handshake is checked against the model; stalled records must hold.
   always @(negedge clk) begin
      logic [10:0] e;
      if (!rst_n) stalled = 1'b0;
      else if (wr_valid) begin
         if (stalled) begin
            check("hold_addr", wr_addr, held_addr);
            check("hold_data", wr_data, held_data);
         end
         if (wr_ready) begin
            stalled = 1'b0;
            check("write_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rec_data", wr_data, e);
               check("rec_addr", wr_addr, exp_addr);
               exp_addr++;
               got.push_back(wr_data);
            end
         end else begin
            stalled   = 1'b1;
            held_addr = wr_addr;
            held_data = wr_data;
         end
      end else stalled = 1'b0;
   end

   always @(negedge clk) begin
      if (rst_n && s_watch && s_valid && wr_ready) begin
         s_writes++;
         check("small_rec", s_data, 11'h003);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      model_clear();
      idle(3);
      check("rst_valid", wr_valid, 1'b0);
      check("rst_data", wr_data, 11'h000);
      check("rst_addr", wr_addr, 9'd0);
      check("rst_measure", measure, 8'd0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_full", score_full, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      idle(1);

      // Four quarter notes, sink always ready.
      do_reset();
      wr_ready = 1'b1;
      repeat (4) push(1'b0, 2'd1, 6'd12, 1'b1);
      drain_and_check("quarters");
      check("q_rec0", got[0], 11'h04C);
      check("q_rec3", got[3], 11'h04C);
      check("q_count", got.size(), 4 + B);
      check("q_measure_lit", measure, 8'd1);
`ifdef SCHED_BARLINE_EN
      check("q_bar", got[4], 11'h400);
`endif

      // Whole note starting at pos 6 straddles the barline.
      do_reset();
      repeat (3) push(1'b0, 2'd1, 6'd1, 1'b1);
      push(1'b0, 2'd3, 6'd20, 1'b1);
      drain_and_check("straddle");
      check("st_q1", got[0], 11'h041);
      check("st_tie_q", got[3], 11'h254);
      check("st_tie_h", got[4 + B], 11'h294);
      check("st_end_q", got[5 + B], 11'h054);
`ifdef SCHED_BARLINE_EN
      check("st_bar", got[4], 11'h400);
`endif

      // Sink stalls mid-record, then rests (tone forced to 0, never tied).
      do_reset();
      wr_ready = 1'b0;
      push(1'b0, 2'd2, 6'd33, 1'b1);
      idle(3);
      check("stall_valid", wr_valid, 1'b1);
      idle(5);
      check("stall_nowrite", got.size(), 0);
      wr_ready = 1'b1;
      push(1'b1, 2'd0, 6'd9, 1'b1);
      push(1'b1, 2'd3, 6'd0, 1'b1);
      drain_and_check("stall");
      check("stall_rec0", got[0], 11'h0A1);
      check("stall_rest8", got[1], 11'h100);
      check("stall_rest4", got[2], 11'h140);
      check("stall_addr", wr_addr, 6 + B);

      // Overflow: one event parked in EMIT, then nine pushes into a stalled queue.
      do_reset();
      wr_ready = 1'b0;
      push(1'b0, 2'd3, 6'd5, 1'b1);
      idle(4);
      for (int i = 1; i <= 8; i++) push(1'b0, 2'd0, 6'(i), 1'b1);
      check("ovf_not_yet", overflow, 1'b0);
      push(1'b0, 2'd0, 6'd9, 1'b0);
      exp_ovf = 1'b1;
      check("ovf_set", overflow, 1'b1);
      idle(2);
      wr_ready = 1'b1;
      drain_and_check("overflow");
      check("ovf_count", got.size(), 9 + 2 * B);

      // Reset while a record is pending.
      do_reset();
      wr_ready = 1'b0;
      push(1'b0, 2'd1, 6'd7, 1'b1);
      idle(4);
      check("pre_rst_valid", wr_valid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("async_valid", wr_valid, 1'b0);
      check("async_data", wr_data, 11'h000);
      check("async_busy", busy, 1'b0);
      model_clear();
      idle(2);
      rst_n = 1'b1;
      wr_ready = 1'b1;
      idle(1);
      push(1'b0, 2'd1, 6'd8, 1'b1);
      drain_and_check("post_rst");
      check("post_rst_rec", got[0], 11'h048);
      check("post_rst_count", got.size(), 1);

      // Score memory exhaustion on the 3-bit-address instance.
      do_reset();
      s_watch = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(1'b0, 2'd0, 6'd3, 1'b1);
         idle(1);
      end
      drain_and_check("halt_main");
      idle(5);
      check("halt_writes", s_writes, 8);
      check("halt_full", s_full, 1'b1);
      check("halt_valid", s_valid, 1'b0);
      check("halt_addr", s_addr, 3'd7);
      check("halt_busy", s_busy, 1'b1);
      check("halt_no_ovf", s_overflow, 1'b0);
      check("main_not_full", score_full, 1'b0);
      s_watch = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
